// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter and the cache controllers.
package mem_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 28;
    localparam int unsigned DEF_DATA_W = 128;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage : mem_arbiter_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-memory port between the I-cache and D-cache.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    // I-cache side
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    // D-cache side
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    // Memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // Performance counters
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    arb_state_e state_q;
    arb_state_e state_d;
    req_id_e    last_q;
    req_id_e    last_d;

    logic i_req_c;
    logic d_req_c;
    logic i_done_c;
    logic d_done_c;

    assign i_req_c = i_mem_read;
    assign d_req_c = d_mem_read | d_mem_write;

    // Grant state and last-served requester; last starts at D so I wins the first tie.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_D;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Arbitration and completion; a dropped request aborts without touching last or counters.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        i_done_c = 1'b0;
        d_done_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_c && d_req_c) begin
                    state_d = (last_q == REQ_D) ? ST_GRANT_I : ST_GRANT_D;
                end else if (i_req_c) begin
                    state_d = ST_GRANT_I;
                end else if (d_req_c) begin
                    state_d = ST_GRANT_D;
                end
            end
            ST_GRANT_I: begin
                if (!i_req_c) begin
                    state_d = ST_IDLE;
                end else if (mem_ready) begin
                    state_d  = ST_IDLE;
                    last_d   = REQ_I;
                    i_done_c = 1'b1;
                end
            end
            ST_GRANT_D: begin
                if (!d_req_c) begin
                    state_d = ST_IDLE;
                end else if (mem_ready) begin
                    state_d  = ST_IDLE;
                    last_d   = REQ_D;
                    d_done_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pass the granted cache straight through to memory; a D read+write goes out as a write.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_GRANT_I: begin
                mem_read = i_mem_read;
                mem_addr = i_mem_addr;
            end
            ST_GRANT_D: begin
                mem_read  = d_mem_read & ~d_mem_write;
                mem_write = d_mem_write;
                mem_addr  = d_mem_addr;
                mem_wdata = d_mem_wdata;
            end
            default: begin
                mem_read = 1'b0;
            end
        endcase
    end

    assign i_mem_ready = i_done_c;
    assign d_mem_ready = d_done_c;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_i_cnt (
        .clk     (clk),
        .clr_n_i (proc_reset_n),
        .inc_i   (i_done_c),
        .cnt_o   (i_grant_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_d_cnt (
        .clk     (clk),
        .clr_n_i (proc_reset_n),
        .inc_i   (d_done_c),
        .cnt_o   (d_grant_cnt)
    );

endmodule : mem_arbiter
